// File: rtl/icache_tag_pkg.sv
// Shared types and default geometry for the icache tag controller and its tag SRAM.
package icache_tag_pkg;

    localparam int SET_W = 4;
    localparam int TAG_W = 23;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        INIT,
        INIT_CLOSE,
        IDLE,
        FILL_CLOSE
    } tag_ctrl_state_t;

endpackage

// File: rtl/icache_tag_stats.sv
// Saturating hit/miss counters for tag lookups; built only with ICACHE_TAG_STATS_EN.
module icache_tag_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        resp_valid_i,
    input  logic        resp_hit_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);
    import icache_tag_pkg::*;

    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (clr_i) begin
            hit_d  = '0;
            miss_d = '0;
        end else if (resp_valid_i) begin
            if (resp_hit_i) begin
                if (hit_q != '1) hit_d = hit_q + 32'd1;
            end else begin
                if (miss_q != '1) miss_d = miss_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/icache_tag_ctrl.sv
// Drives the single-port icache tag SRAM: post-reset/flush invalidate sweep, fills and lookups.
// Optional hit/miss counters are enabled with the ICACHE_TAG_STATS_EN macro.
module icache_tag_ctrl #(
    parameter int SET_W = icache_tag_pkg::SET_W,
    parameter int TAG_W = icache_tag_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [SET_W-1:0] resp_set,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [SET_W-1:0] fill_set,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_all,
    output logic             busy,
    output logic             sram_csb0,
    output logic             sram_web0,
    output logic [SET_W-1:0] sram_addr0,
    output logic [TAG_W:0]   sram_din0,
    input  logic [TAG_W:0]   sram_dout0
`ifdef ICACHE_TAG_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);
    import icache_tag_pkg::*;

    localparam logic [SET_W-1:0] LAST_SET = {SET_W{1'b1}};

    tag_ctrl_state_t  state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SET_W-1:0] fill_set_q, fill_set_d;
    logic             flush;
    logic             csb, web;
    logic [SET_W-1:0] addr;
    logic [TAG_W:0]   din;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = 1'b0;
        set_d      = set_q;
        tag_d      = tag_q;
        fill_set_d = fill_set_q;
        flush      = 1'b0;
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        csb        = 1'b1;
        web        = 1'b1;
        addr       = '0;
        din        = '0;
        case (state_q)
            INIT: begin
                csb   = 1'b0;
                web   = 1'b0;
                addr  = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) state_d = INIT_CLOSE;
            end
            // Close cycle after the last sweep write lets it commit; read data is ignored.
            INIT_CLOSE: begin
                csb     = 1'b0;
                addr    = LAST_SET;
                state_d = IDLE;
            end
            IDLE: begin
                if (inv_all) begin
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = INIT;
                end else if (fill_valid) begin
                    fill_ready = 1'b1;
                    csb        = 1'b0;
                    web        = 1'b0;
                    addr       = fill_set;
                    din        = {1'b1, fill_tag};
                    fill_set_d = fill_set;
                    state_d    = FILL_CLOSE;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        csb    = 1'b0;
                        addr   = req_set;
                        set_d  = req_set;
                        tag_d  = req_tag;
                        pend_d = 1'b1;
                    end
                end
            end
            FILL_CLOSE: begin
                csb     = 1'b0;
                addr    = fill_set_q;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            set_q   <= set_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q      <= tag_d;
        fill_set_q <= fill_set_d;
    end

    // The macro has no reset, so keep its port quiet while rst is held.
    assign sram_csb0  = rst ? 1'b1 : csb;
    assign sram_web0  = rst ? 1'b1 : web;
    assign sram_addr0 = rst ? '0   : addr;
    assign sram_din0  = rst ? '0   : din;

    assign resp_valid = pend_q;
    assign resp_set   = set_q;
    assign resp_hit   = pend_q && sram_dout0[TAG_W] && (sram_dout0[TAG_W-1:0] == tag_q);
    assign busy       = (state_q != IDLE);

`ifdef ICACHE_TAG_STATS_EN
    icache_tag_stats u_stats (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (flush),
        .resp_valid_i (resp_valid),
        .resp_hit_i   (resp_hit),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Scoreboard bench for icache_tag_ctrl with a behavioural model of the tag SRAM port.
module tb_icache_tag_ctrl;
    import icache_tag_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_set;
    logic [22:0] req_tag;
    logic        resp_valid, resp_hit;
    logic [3:0]  resp_set;
    logic        fill_valid, fill_ready;
    logic [3:0]  fill_set;
    logic [22:0] fill_tag;
    logic        inv_all, busy;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_addr0;
    logic [23:0] sram_din0;
    tag_entry_t  sram_dout0;
`ifdef ICACHE_TAG_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_tag_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_set   (resp_set),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_set   (fill_set),
        .fill_tag   (fill_tag),
        .inv_all    (inv_all),
        .busy       (busy),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
`ifdef ICACHE_TAG_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // SRAM model: capture on csb0=0, read data next cycle, write commits one edge after capture.
    tag_entry_t mem [16];
    logic       wpend = 1'b0;
    logic [3:0] waddr;
    tag_entry_t wdata;
    always @(posedge clk) begin
        if (wpend) mem[waddr] <= wdata;
        wpend <= !sram_csb0 && !sram_web0;
        if (!sram_csb0) begin
            waddr <= sram_addr0;
            wdata <= sram_din0;
            if (sram_web0) sram_dout0 <= mem[sram_addr0];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] set;
        logic       hit;
    } exp_t;

    exp_t        sb_q[$];
    logic        ref_v [16];
    logic [22:0] ref_t [16];
    int          hits_exp, miss_exp;

    always @(negedge clk) begin
        if (rst || inv_all) begin
            for (int i = 0; i < 16; i++) ref_v[i] = 1'b0;
            hits_exp = 0;
            miss_exp = 0;
        end
        if (!rst) begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("resp_set", 64'(resp_set), 64'(e.set));
                    chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                    if (e.hit) hits_exp++;
                    else miss_exp++;
                end
            end
            if (req_valid && req_ready)
                sb_q.push_back('{set: req_set, hit: ref_v[req_set] && (ref_t[req_set] == req_tag)});
            if (fill_valid && fill_ready) begin
                ref_v[fill_set] = 1'b1;
                ref_t[fill_set] = fill_tag;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_set", 64'(resp_set), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_csb", 64'(sram_csb0), 64'd1);
        chk("rst_web", 64'(sram_web0), 64'd1);
        chk("rst_addr", 64'(sram_addr0), 64'd0);
        chk("rst_din", 64'(sram_din0), 64'd0);
`ifdef ICACHE_TAG_STATS_EN
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
`endif
    endtask

    // Starts just after the edge entering INIT; ends at the start of the first idle cycle.
    task automatic check_sweep();
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                chk("swp_csb", 64'(sram_csb0), 64'd0);
                chk("swp_web", 64'(sram_web0), 64'd0);
                chk("swp_addr", 64'(sram_addr0), 64'(k - 1));
                chk("swp_din", 64'(sram_din0), 64'd0);
                chk("swp_busy", 64'(busy), 64'd1);
                chk("swp_ready", 64'(req_ready), 64'd0);
            end else if (k == 17) begin
                chk("close_csb", 64'(sram_csb0), 64'd0);
                chk("close_web", 64'(sram_web0), 64'd1);
                chk("close_addr", 64'(sram_addr0), 64'd15);
                chk("close_busy", 64'(busy), 64'd1);
                chk("close_ready", 64'(req_ready), 64'd0);
            end else begin
                chk("first_ready", 64'(req_ready), 64'd1);
                chk("first_idle_busy", 64'(busy), 64'd0);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic lookup(input logic [3:0] s, input logic [22:0] t);
        logic done;
        done = 1'b0;
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("lookup_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic fill(input logic [3:0] s, input logic [22:0] t);
        logic done;
        done = 1'b0;
        fill_valid = 1'b1;
        fill_set   = s;
        fill_tag   = t;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (fill_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("fill_timeout", 64'd0, 64'd1);
        fill_valid = 1'b0;
    endtask

    task automatic pulse_inv();
        @(posedge clk); #1;
        inv_all = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_set = '0; req_tag = '0;
        fill_valid = 1'b0; fill_set = '0; fill_tag = '0;
        inv_all = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        check_sweep();

        lookup(4'd3, 23'h12345);
        fill(4'd3, 23'h12345);
        lookup(4'd3, 23'h12345);
        lookup(4'd3, 23'h12346);
        @(posedge clk); #1;

        // Lookups to sets 1,2,3 with a competing fill in the second cycle.
        req_valid = 1'b1; req_set = 4'd1; req_tag = 23'h00001;
        @(negedge clk);
        chk("b2b_acc1", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_set = 4'd2; req_tag = 23'h00002;
        fill_valid = 1'b1; fill_set = 4'd7; fill_tag = 23'h00ABC;
        @(negedge clk);
        chk("fillwin_fready", 64'(fill_ready), 64'd1);
        chk("fillwin_rready", 64'(req_ready), 64'd0);
        chk("fillwin_resp_v", 64'(resp_valid), 64'd1);
        chk("fillwin_resp_set", 64'(resp_set), 64'd1);
        @(posedge clk); #1;
        fill_valid = 1'b0;
        @(negedge clk);
        chk("fclose_rready", 64'(req_ready), 64'd0);
        chk("fclose_resp_v", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_acc2", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_set = 4'd3; req_tag = 23'h12345;
        @(negedge clk);
        chk("b2b_acc3", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lookup(4'd7, 23'h00ABC);

        for (int i = 0; i < 40; i++) begin
            logic [22:0] t;
            case ($urandom_range(0, 2))
                0:       t = 23'h12345;
                1:       t = 23'h12346;
                default: t = 23'h7ABCD;
            endcase
            if ($urandom_range(0, 3) == 0) fill(4'($urandom_range(0, 7)), t);
            else lookup(4'($urandom_range(0, 7)), t);
        end

        for (int s = 8; s < 13; s++) fill(4'(s), 23'h55500 + 23'(s));
        lookup(4'd9, 23'h55509);
        @(posedge clk); #1;
`ifdef ICACHE_TAG_STATS_EN
        @(negedge clk);
        chk("pre_inv_hits", 64'(hit_count), 64'(hits_exp));
        chk("pre_inv_misses", 64'(miss_count), 64'(miss_exp));
        @(posedge clk); #1;
`endif
        pulse_inv();
        check_sweep();
`ifdef ICACHE_TAG_STATS_EN
        chk("post_sweep_hits", 64'(hit_count), 64'd0);
        chk("post_sweep_misses", 64'(miss_count), 64'd0);
`endif
        for (int s = 0; s < 16; s++) lookup(4'(s), (s >= 8 && s < 13) ? 23'h55500 + 23'(s) : 23'h12345);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a sweep.
        pulse_inv();
        for (int k = 1; k <= 8; k++) @(negedge clk);
        chk("pre_rst_addr", 64'(sram_addr0), 64'd7);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        check_sweep();
        fill(4'd4, 23'h00444);
        lookup(4'd4, 23'h00444);
        lookup(4'd5, 23'h00444);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef ICACHE_TAG_STATS_EN
        chk("end_hits", 64'(hit_count), 64'(hits_exp));
        chk("end_misses", 64'(miss_count), 64'(miss_exp));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
- Initiator/controller for the single-port 16x24 icache tag SRAM macro (`icache_tag_array`).
- Converts cache-side lookup and fill requests into SRAM port cycles (`csb0`/`web0`/`addr0`/`din0`) and returns hit/miss from `dout0`.
- The SRAM has no reset, so this block sweeps every entry invalid after reset and on a flush request.
- Sits between the icache control FSM and the tag SRAM instance.

Parameters:
- SET_W, 4, set index width; SRAM depth = 1<<SET_W.
- TAG_W, 23, tag width; SRAM word = TAG_W+1 (bit TAG_W = valid).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when valid&&ready
- req_set  in  SET_W  lookup set
- req_tag  in  TAG_W  lookup tag
- resp_valid  out  1  lookup result valid (one-cycle pulse, no backpressure)
- resp_hit  out  1  entry valid and tag match
- resp_set  out  SET_W  set of responding lookup
- fill_valid  in  1  tag write request
- fill_ready  out  1  fill accepted when valid&&ready
- fill_set  in  SET_W  fill set
- fill_tag  in  TAG_W  fill tag
- inv_all  in  1  flush pulse: invalidate all sets
- busy  out  1  high in any state other than IDLE
- sram_csb0  out  1  SRAM chip select, active low
- sram_web0  out  1  SRAM write enable, active low
- sram_addr0  out  SET_W  SRAM address
- sram_din0  out  TAG_W+1  SRAM write data
- sram_dout0  in  TAG_W+1  SRAM read data (valid the cycle after a read is issued)

Behaviour:
- SRAM port protocol:
  - Inputs are captured on the edge where `csb0`=0.
  - Read data appears the following cycle.
  - A write commits one edge after capture.
  - While `csb0`=1 the captured `web0` persists, so every write is followed by one "close" cycle (`csb0`=0, `web0`=1, same address) before the port may idle.
- SRAM outputs are combinational from state and accepted requests. While `rst`=1 they are forced to `csb0`=1, `web0`=1, `addr`=0, `din`=0.
- Reset values: `req_ready`=0, `fill_ready`=0, `resp_valid`=0, `resp_hit`=0, `resp_set`=0, `busy`=1, state=INIT, sweep counter=0.
- States:
  - INIT: `csb0`=0, `web0`=0, `addr`=cnt, `din`=0; cnt increments each cycle. At cnt = 2^SET_W-1, go to INIT_CLOSE.
  - INIT_CLOSE: read addr 2^SET_W-1, result discarded; go to IDLE. The first `req_ready`=1 is cycle 18 after reset release (defaults).
  - IDLE, priority order:
    1. `inv_all` -> INIT, cnt=0.
    2. `fill_valid`: `fill_ready`=1, `req_ready`=0; write {1,fill_tag} to fill_set; go to FILL_CLOSE.
    3. Otherwise `req_ready`=1: on accept, read req_set, register req_tag/req_set; stay in IDLE.
  - FILL_CLOSE: read fill_set_q, no response; go to IDLE. Both readies are 0.
- Lookup latency is 1:
  - Accepted in cycle N -> `resp_valid`=1 in N+1, with `resp_hit` = dout[TAG_W] && dout[TAG_W-1:0]==tag_q.
  - Back-to-back lookups give 1 response/cycle.
- A response owed from cycle N is always delivered in N+1, even if N+1 is a fill-accept cycle or the first INIT cycle.
- Read-after-fill to the same set sees the new tag: the write commits on the close edge.
- An `inv_all` arriving outside IDLE is ignored. Callers hold it until `busy`=0.
- Async reset mid-sweep or mid-fill restarts INIT at cnt=0. A partially committed SRAM write is harmless because the sweep rewrites all sets.

Optional Feature:
- Macro ICACHE_TAG_STATS_EN.
- Defined: adds outputs `hit_count` and `miss_count` (32 bits each, saturating).
  - Each increments on `resp_valid` with `resp_hit`=1 / 0 respectively.
  - Both clear on `rst` and on entry to INIT.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package `icache_tag_pkg`:
  - constants SET_W and TAG_W;
  - packed struct `tag_entry_t` {valid, tag};
  - enum `tag_ctrl_state_t` {INIT, INIT_CLOSE, IDLE, FILL_CLOSE}.
- Sub-module `icache_tag_stats` (counters) is instantiated only under ICACHE_TAG_STATS_EN. All else is flat.

Test Plan:
- Reset release: `addr0` 0..15 written with `din`=0 (`web0`=0) in 16 cycles, then one close read, then `req_ready`=1 in cycle 18; `busy` falls the same cycle.
- Lookup set 3 tag 0x12345 after reset -> next cycle `resp_valid`=1, `resp_hit`=0, `resp_set`=3.
- Fill set 3 tag 0x12345, then lookup the same set the first ready cycle -> `resp_hit`=1. Lookup tag 0x12346 -> `resp_hit`=0.
- Lookups to sets 1, 2, 3 on consecutive cycles with `fill_valid` asserted in the 2nd cycle:
  - fill wins and `req_ready`=0 for 2 cycles;
  - set 1's response still appears in the fill cycle;
  - sets 2 and 3 are served afterwards;
  - no response is lost or duplicated.
- Fill 5 sets, pulse `inv_all`:
  - 17-cycle sweep follows;
  - all subsequent lookups miss;
  - with ICACHE_TAG_STATS_EN, counters read 0 after the sweep.
- Assert `rst` at sweep cnt=7 -> all outputs take reset values immediately; after release the sweep restarts at addr 0.
